// File: rtl/rng_pkg.sv
// Shared constants and the single-step LFSR function for the rng generator.
// Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifting toward the MSB.
package rng_pkg;

  localparam logic [15:0] RNG_DEFAULT_SEED = 16'hface;
  localparam logic [15:0] RNG_ZERO_SEED    = 16'h0001;

  localparam int RNG_TAP_0 = 15;
  localparam int RNG_TAP_1 = 13;
  localparam int RNG_TAP_2 = 12;
  localparam int RNG_TAP_3 = 10;

  function automatic logic [15:0] rng_lfsr_step(input logic [15:0] s);
    logic new_bit;
    new_bit = s[RNG_TAP_0] ^ s[RNG_TAP_1] ^ s[RNG_TAP_2] ^ s[RNG_TAP_3];
    return {s[14:0], new_bit};
  endfunction

endpackage

// File: rtl/rng.sv
// 16-bit pseudo-random word generator: sixteen unrolled LFSR steps per clock,
// so every output bit is fresh each cycle.
module rng
  import rng_pkg::*;
#(
  parameter logic [15:0] S = RNG_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rng_o
);

  // The all-zero state never leaves itself, so a zero seed is replaced.
  localparam logic [15:0] SEED = (S == 16'h0000) ? RNG_ZERO_SEED : S;

  logic [15:0] state_r;
  logic [15:0] state_next_s;

  // Sixteen chained single steps.
  always_comb begin
    state_next_s = state_r;
    for (int i = 0; i < 16; i++) begin
      state_next_s = rng_lfsr_step(state_next_s);
    end
  end

  // State register with synchronous seed load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEED;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign rng_o = state_r;

endmodule

// File: tb/tb_rng.sv
// Directed self-checking bench for rng: seeds, zero-seed substitution, period,
// mid-sequence reset, reference-model comparison and per-bit balance.
module tb_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rng_face;
  logic [15:0] rng_zero;
  logic [15:0] rng_a;
  logic [15:0] rng_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rng #(.S(16'hface)) u_face (.clk(clk), .reset(reset), .rng_o(rng_face));
  rng #(.S(16'h0000)) u_zero (.clk(clk), .reset(reset), .rng_o(rng_zero));
  rng #(.S(16'h1234)) u_a    (.clk(clk), .reset(reset), .rng_o(rng_a));
  rng #(.S(16'h4321)) u_b    (.clk(clk), .reset(reset), .rng_o(rng_b));

  // Reference: one clock = 16 shifts, feedback is the parity of taps 15,13,12,10.
  function automatic logic [15:0] model16(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < 16; k++) begin
      v = {v[14:0], ^(v & 16'hb400)};
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  logic [15:0] first_run [1:32];
  logic [15:0] mf, mz, ma, mb;
  int model_err;
  int replay_err;
  int early_face;
  int zero_seen;
  int differ;
  int ones [16];

  initial begin
    reset = 1'b1;
    step();
    check16("reset_face", rng_face, 16'hface);
    check16("reset_zero_seed", rng_zero, 16'h0001);
    check16("reset_a", rng_a, 16'h1234);
    check16("reset_b", rng_b, 16'h4321);

    reset = 1'b0;
    step();
    check16("first_face", rng_face, 16'h9e53);
    check16("first_zero_seed", rng_zero, 16'h002d);

    // Free-run 1000 clocks, recording the opening words for the replay check.
    first_run[1] = rng_face;
    for (int i = 2; i <= 1000; i++) begin
      step();
      if (i <= 32) first_run[i] = rng_face;
    end

    reset = 1'b1;
    step();
    check16("midrun_reset_face", rng_face, 16'hface);
    reset = 1'b0;

    mf = 16'hface;
    mz = 16'h0001;
    ma = 16'h1234;
    mb = 16'h4321;
    model_err  = 0;
    replay_err = 0;
    early_face = 0;
    zero_seen  = 0;
    differ     = 0;
    for (int b = 0; b < 16; b++) ones[b] = 0;

    for (int i = 1; i <= 65535; i++) begin
      step();
      mf = model16(mf);
      mz = model16(mz);
      ma = model16(ma);
      mb = model16(mb);
      if (i == 1) check16("replay_first_9e53", rng_face, 16'h9e53);
      if (i <= 32 && rng_face !== first_run[i]) replay_err++;
      if (i <= 10000) begin
        if (rng_face !== mf || rng_zero !== mz || rng_a !== ma || rng_b !== mb) model_err++;
        for (int b = 0; b < 16; b++) ones[b] += int'(rng_face[b]);
      end
      if (rng_a !== rng_b) differ++;
      if (rng_face === 16'h0000 || rng_zero === 16'h0000) zero_seen++;
      if (i < 65535 && rng_face === 16'hface) early_face++;
    end

    check16("period_return_face", rng_face, 16'hface);
    check_int("replay_mismatches", replay_err, 0);
    check_int("model_mismatches", model_err, 0);
    check_int("early_face_repeats", early_face, 0);
    check_int("zero_words_seen", zero_seen, 0);
    check_range("a_b_differ_cycles", differ, 1, 65535);
    for (int b = 0; b < 16; b++) begin
      check_range($sformatf("bit%0d_ones", b), ones[b], 4800, 5200);
    end

    // One more clock past the period continues with the second word.
    step();
    check16("period_wrap_9e53", rng_face, 16'h9e53);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
